data_ram_responder: RTL and testbench

Data-memory responder for the five-stage pipeline. It sits on the far side of the MEM stage's data port (`dm_addr`, `dm_wen`, `dm_wdata`, `dm_rdata`). It performs byte-lane writes and returns synchronous reads exactly one cycle after the address is presented, which is the latency the MEM stage's two-beat load completion is built around. It also provides an independent registered debug read port for the board display, and zero-fills the whole array after reset.

---
 rtl/dm_pkg.sv | 19 +
 rtl/dm_bram.sv | 29 ++
 rtl/data_ram_responder.sv | 102 ++++++++++
 tb/tb_data_ram_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: state encoding, lane width
// and the byte-address to word-index decode used by both read ports.
package dm_pkg;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

  localparam int DM_LANE_W = 8;
  localparam int DM_LANES  = 4;
  localparam int DM_WORD_W = DM_LANE_W * DM_LANES;

  // Word index is bits [addr_w+1:2]; the byte offset and the aliased upper bits drop out.
  function automatic logic [31:0] dm_word_idx(input logic [31:0] addr, input int addr_w);
    return (addr >> 2) & ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/dm_bram.sv
// Byte-lane-masked single write port plus two read-first synchronous read ports,
// coded in the plain style that maps onto block RAM.
module dm_bram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic [DM_LANES-1:0]  we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DM_WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [DM_WORD_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [DM_WORD_W-1:0] rdata_b
);

  logic [DM_WORD_W-1:0] mem [2**ADDR_W];

  // Non-blocking reads of mem see the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DM_LANES; i++) begin
      if (we[i]) mem[waddr][i*DM_LANE_W +: DM_LANE_W] <= wdata[i*DM_LANE_W +: DM_LANE_W];
    end
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder for the MEM stage: 1-cycle synchronous reads, byte-lane
// writes, a debug read port, and a full zero-fill after every reset.
//
//   state    | meaning
//   DM_CLEAR | zero-filling word clr_idx each cycle; CPU writes blocked, outputs 0
//   DM_READY | normal read/write service until the next rst
module data_ram_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data,
  output logic        init_busy,
  output logic [15:0] store_cnt
);

  dm_state_t            state_q, state_d;
  logic [ADDR_W-1:0]    clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0]    cpu_idx, dbg_idx;
  logic [DM_LANES-1:0]  ram_we;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [DM_WORD_W-1:0] ram_wdata;
  logic [DM_WORD_W-1:0] ram_rdata_a, ram_rdata_b;
  logic                 rd_valid_q;

  assign cpu_idx = ADDR_W'(dm_word_idx(dm_addr, ADDR_W));
  assign dbg_idx = ADDR_W'(dm_word_idx(test_addr, ADDR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DM_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      DM_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (&clr_idx_q) state_d = DM_READY;
      end
      DM_READY: state_d = DM_READY;
      default:  state_d = DM_CLEAR;
    endcase
  end

  // Write source: the clear sweep owns the port until READY; rst blocks both.
  always_comb begin
    ram_we    = '0;
    ram_waddr = cpu_idx;
    ram_wdata = dm_wdata;
    if (!rst) begin
      if (state_q == DM_CLEAR) begin
        ram_we    = '1;
        ram_waddr = clr_idx_q;
        ram_wdata = '0;
      end else begin
        ram_we    = dm_wen;
      end
    end
  end

  dm_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (cpu_idx),
    .rdata_a (ram_rdata_a),
    .raddr_b (dbg_idx),
    .rdata_b (ram_rdata_b)
  );

  // The RAM itself has no reset, so read data is qualified by a flag that
  // tracks whether the read was launched while READY.
  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= (state_q == DM_READY);
  end

  assign dm_rdata  = rd_valid_q ? ram_rdata_a : '0;
  assign test_data = rd_valid_q ? ram_rdata_b : '0;
  assign init_busy = (state_q == DM_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) store_cnt <= '0;
    else if (state_q == DM_READY && dm_wen != 4'b0000) store_cnt <= store_cnt + 16'd1;
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed and randomized checks of data_ram_responder (ADDR_W=4) against a
// word-array reference model with read-first semantics.
module tb_data_ram_responder;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr, dm_wdata, test_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_rdata, test_data;
  logic        init_busy;
  logic [15:0] store_cnt;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] model [DEPTH];
  logic [15:0] m_cnt;

  data_ram_responder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .dm_addr   (dm_addr),
    .dm_wen    (dm_wen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .test_addr (test_addr),
    .test_data (test_data),
    .init_busy (init_busy),
    .store_cnt (store_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One cycle of CPU/debug traffic in READY; inputs driven at negedge, outputs checked at the next negedge.
  task automatic step(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                      input logic [31:0] ta, input bit chk_en);
    logic [31:0] exp_r, exp_t;
    int wi;
    dm_addr = a; dm_wen = w; dm_wdata = d; test_addr = ta;
    @(posedge clk);
    exp_r = model[widx(a)];
    exp_t = model[widx(ta)];
    wi = widx(a);
    for (int i = 0; i < 4; i++) if (w[i]) model[wi][i*8 +: 8] = d[i*8 +: 8];
    if (w != 4'b0000) m_cnt = m_cnt + 16'd1;
    @(negedge clk);
    dm_wen = 4'b0000;
    if (chk_en) begin
      chk("rdata", dm_rdata, exp_r);
      chk("tdata", test_data, exp_t);
      chk("store_cnt", {16'h0, store_cnt}, {16'h0, m_cnt});
      chk("busy_ready", {31'h0, init_busy}, 32'h0);
    end
  endtask

  // Reset, optional rst re-pulse after pulse_at clear cycles, optional store held during the clear.
  task automatic do_reset(input int pulse_at, input bit store_in_clear);
    int busy_cycles;
    bit nonzero_seen;
    dm_wen = 4'b0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, init_busy}, 32'h1);
    chk("rst_rdata", dm_rdata, 32'h0);
    chk("rst_tdata", test_data, 32'h0);
    chk("rst_cnt", {16'h0, store_cnt}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    m_cnt = 16'h0;
    if (store_in_clear) begin
      dm_addr = 32'h4; dm_wen = 4'hF; dm_wdata = 32'hFFFF_FFFF;
    end
    if (pulse_at > 0) begin
      repeat (pulse_at) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    busy_cycles  = 0;
    nonzero_seen = 1'b0;
    while (init_busy && busy_cycles < 40) begin
      busy_cycles++;
      if (dm_rdata !== 32'h0 || test_data !== 32'h0) nonzero_seen = 1'b1;
      @(negedge clk);
    end
    dm_wen = 4'b0000;
    chk("busy_cycles", busy_cycles, 32'd16);
    chk("clear_out_zero", {31'h0, nonzero_seen}, 32'h0);
    chk("clear_cnt", {16'h0, store_cnt}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; dm_addr = '0; dm_wen = '0; dm_wdata = '0; test_addr = '0; m_cnt = '0;
    @(negedge clk);

    // 1: clear timing and full zero sweep on both ports
    do_reset(0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(i * 4, 4'b0000, 32'h0, (DEPTH - 1 - i) * 4, 1'b1);

    // 2: word store and 1-cycle read
    step(32'h10, 4'b1111, 32'h1234_5678, 32'h0, 1'b1);
    step(32'h10, 4'b0000, 32'h0, 32'h10, 1'b1);
    chk("t2_rd", dm_rdata, 32'h1234_5678);
    chk("t2_cnt", {16'h0, store_cnt}, 32'd1);

    // 3: byte lane stores
    step(32'h12, 4'b0100, 32'h00AB_0000, 32'h0, 1'b1);
    step(32'h10, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t3_byte", dm_rdata, 32'h12AB_5678);
    step(32'h12, 4'b1100, 32'hCAFE_0000, 32'h0, 1'b1);
    step(32'h10, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t3_half", dm_rdata, 32'hCAFE_5678);

    // 4: read-during-write on both ports is read-first
    step(32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h10, 1'b1);
    chk("t4_rdw", dm_rdata, 32'hCAFE_5678);
    chk("t4_dbg_rdw", test_data, 32'hCAFE_5678);
    step(32'h10, 4'b0000, 32'h0, 32'h10, 1'b1);
    chk("t4_new", dm_rdata, 32'hDEAD_BEEF);

    // 5: store during clear ignored, rst mid-clear restarts, address aliasing
    do_reset(7, 1'b1);
    step(32'h4, 4'b0000, 32'h0, 32'h10, 1'b1);
    chk("t5_blocked", dm_rdata, 32'h0);
    chk("t5_wiped", test_data, 32'h0);
    step(32'h40, 4'b0001, 32'h0000_0055, 32'h0, 1'b1);
    step(32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t5_alias", dm_rdata, 32'h0000_0055);

    // randomized traffic, including aliased upper bits and same-word debug reads
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, ta;
      a  = $urandom;
      ta = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step(a, 4'($urandom_range(0, 15)), $urandom, ta, 1'b1);
    end

    // 6: store counter wrap
    do_reset(0, 1'b0);
    for (int n = 0; n < 65534; n++) step(32'($urandom_range(0, 63)), 4'b0001, 32'h0, 32'h0, 1'b0);
    step(32'h8, 4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t6_pre", {16'h0, store_cnt}, 32'h0000_FFFE);
    step(32'h8, 4'b1111, 32'h1, 32'h0, 1'b1);
    chk("t6_ffff", {16'h0, store_cnt}, 32'h0000_FFFF);
    step(32'h8, 4'b0010, 32'h200, 32'h0, 1'b1);
    chk("t6_wrap", {16'h0, store_cnt}, 32'h0000_0000);
    step(32'h8, 4'b0000, 32'h0, 32'h8, 1'b1);
    chk("t6_hold", {16'h0, store_cnt}, 32'h0000_0000);
    step(32'h8, 4'b1000, 32'h0300_0000, 32'h0, 1'b1);
    chk("t6_one", {16'h0, store_cnt}, 32'h0000_0001);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
